// File: rtl/cdda_sector_feeder.sv
// Streams one raw CD-DA sector from sector memory into the audio FIFO write port.
// Latency: 3 cycles per 16-bit word at best (FETCH, STROBE, HOLD); DONE 1 cycle after the last HOLD.
// Backpressure: FIFO_READY is sampled once per sector before the first fetch; MEM_RD is held until MEM_ACK.
//
// Ports:
//   CLK, nRESET          clock, synchronous active-low reset
//   START, BASE          begin a sector at word address BASE (ignored while BUSY)
//   ABORT                stop the sector; an odd word count is padded with one zero word
//   MUTE                 replace fetched data with 0x0000
//   MEM_RD/ADDR/ACK/DATA memory read handshake (level request, one-cycle ack with data)
//   FIFO_READY           FIFO has room for a whole sector
//   FIFO_WR, FIFO_DOUT   rising-edge write strobe and data to the FIFO
//   BUSY, DONE           not idle / one-cycle completion pulse
module cdda_sector_feeder #(
    parameter int SECTOR_WORDS = 1176,
    parameter int ADDR_W       = 21
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE,
    input  logic              ABORT,
    input  logic              MUTE,
    output logic              MEM_RD,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [15:0]       MEM_DATA,
    input  logic              FIFO_READY,
    output logic              FIFO_WR,
    output logic [15:0]       FIFO_DOUT,
    output logic              BUSY,
    output logic              DONE
);

    localparam int CNT_W = (SECTOR_WORDS > 1) ? $clog2(SECTOR_WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READY,
        S_FETCH,
        S_STROBE,
        S_HOLD,
        S_PAD,
        S_FINISH
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   base_q;
    logic [CNT_W-1:0]    count_q;
    logic                phase_q;     // 1 when an odd number of words has been written
    logic                pad_q;       // current STROBE/HOLD pair is the abort pad word
    logic                mem_rd_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                fifo_wr_q;
    logic [15:0]         fifo_dout_q;
    logic                done_q;

    logic [CNT_W-1:0]    count_d;
    logic [ADDR_W-1:0]   next_addr_d;
    logic                last_word;
    logic                sent_odd;
    logic                abort_hit;

    assign count_d     = count_q + CNT_W'(1);
    assign next_addr_d = base_q + ADDR_W'(count_d);
    assign last_word   = (count_q == CNT_W'(SECTOR_WORDS - 1));

    // A word in STROBE or HOLD is already in the FIFO but the phase bit only
    // toggles at the end of HOLD, so fold it in when deciding whether to pad.
    assign sent_odd = phase_q ^ ((state_q == S_STROBE) || (state_q == S_HOLD));

    // The pad STROBE/HOLD pair belongs to PAD and cannot itself be aborted.
    assign abort_hit = ABORT && !pad_q &&
                       ((state_q == S_WAIT_READY) || (state_q == S_FETCH) ||
                        (state_q == S_STROBE)     || (state_q == S_HOLD));

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            phase_q     <= 1'b0;
            pad_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            fifo_wr_q   <= 1'b0;
            fifo_dout_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_hit) begin
                // FIFO_DOUT is left alone so a word strobed this cycle still
                // holds for the FIFO's second sampling cycle.
                mem_rd_q  <= 1'b0;
                fifo_wr_q <= 1'b0;
                state_q   <= sent_odd ? S_PAD : S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (START) begin
                            base_q  <= BASE;
                            count_q <= '0;
                            phase_q <= 1'b0;
                            pad_q   <= 1'b0;
                            state_q <= S_WAIT_READY;
                        end
                    end
                    S_WAIT_READY: begin
                        if (FIFO_READY) begin
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= base_q;
                            state_q    <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (MEM_ACK) begin
                            fifo_dout_q <= MUTE ? 16'h0000 : MEM_DATA;
                            mem_rd_q    <= 1'b0;
                            fifo_wr_q   <= 1'b1;
                            state_q     <= S_STROBE;
                        end
                    end
                    S_STROBE: begin
                        fifo_wr_q <= 1'b0;
                        state_q   <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (pad_q) begin
                            pad_q   <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            count_q <= count_d;
                            phase_q <= ~phase_q;
                            if (last_word) begin
                                done_q  <= 1'b1;
                                state_q <= S_FINISH;
                            end else begin
                                mem_rd_q   <= 1'b1;
                                mem_addr_q <= next_addr_d;
                                state_q    <= S_FETCH;
                            end
                        end
                    end
                    S_PAD: begin
                        // Entry cycle kept strobe-free with data unchanged; the
                        // zero word is strobed on the following cycle.
                        fifo_dout_q <= 16'h0000;
                        fifo_wr_q   <= 1'b1;
                        pad_q       <= 1'b1;
                        state_q     <= S_STROBE;
                    end
                    S_FINISH: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign MEM_RD    = mem_rd_q;
    assign MEM_ADDR  = mem_addr_q;
    assign FIFO_WR   = fifo_wr_q;
    assign FIFO_DOUT = fifo_dout_q;
    assign DONE      = done_q;
    assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cdda_sector_feeder.sv
// Bench for cdda_sector_feeder: memory responder plus FIFO scoreboard.
// Latency: full-sector timing checked as 2 + 3*SECTOR_WORDS cycles from START to DONE.
// Backpressure: FIFO_READY gating, delayed MEM_ACK and ABORT with pad are exercised.
module tb_cdda_sector_feeder;

    localparam int SW = 1176;
    localparam int AW = 21;

    logic          clk = 1'b0;
    logic          nrst, start, abort, mute, mem_ack, fifo_ready;
    logic [AW-1:0] base;
    logic [15:0]   mem_data;
    logic          mem_rd, fifo_wr, busy, done;
    logic [AW-1:0] mem_addr;
    logic [15:0]   fifo_dout;

    always #5 clk = ~clk;

    cdda_sector_feeder #(.SECTOR_WORDS(SW), .ADDR_W(AW)) dut (
        .CLK(clk), .nRESET(nrst), .START(start), .BASE(base), .ABORT(abort),
        .MUTE(mute), .MEM_RD(mem_rd), .MEM_ADDR(mem_addr), .MEM_ACK(mem_ack),
        .MEM_DATA(mem_data), .FIFO_READY(fifo_ready), .FIFO_WR(fifo_wr),
        .FIFO_DOUT(fifo_dout), .BUSY(busy), .DONE(done)
    );

    int            n_vec, n_err;
    int            acks_given, ack_limit, wait_left, delay_max;
    int            wr_count, done_count, rd_rises, zero_addr_cnt;
    int            cyc, last_wr_cyc, min_gap, max_gap, addr_start_ack;
    bit            first_wr, fixed_en, prev_wr, prev_rd;
    logic [15:0]   prev_dout, fixed_val, exp_w;
    logic [AW-1:0] addr_base, exp_addr;
    logic [15:0]   exp_q[$];

    task automatic kick(input logic [AW-1:0] b);
        @(negedge clk);
        base = b; start = 1'b1;
        addr_base = b; addr_start_ack = acks_given;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int c, output bit ok);
        ok = 1'b0; c = 0;
        while (c < budget && !ok) begin
            @(negedge clk);
            c++;
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        nrst = 1'b0; start = 0; abort = 0; mute = 0; base = '0; fifo_ready = 0;
        repeat (3) @(negedge clk);
        n_vec++; if (mem_rd !== 1'b0)    begin n_err++; $display("FAIL reset_mem_rd got %b want 0", mem_rd); end
        n_vec++; if (mem_addr !== '0)    begin n_err++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        n_vec++; if (fifo_wr !== 1'b0)   begin n_err++; $display("FAIL reset_fifo_wr got %b want 0", fifo_wr); end
        n_vec++; if (fifo_dout !== '0)   begin n_err++; $display("FAIL reset_fifo_dout got %h want 0", fifo_dout); end
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_sector;
        int c, w0, d0; bit ok;
        fifo_ready = 1; delay_max = 0; mute = 0; fixed_en = 0; ack_limit = 1 << 30;
        w0 = wr_count; d0 = done_count;
        first_wr = 1; min_gap = 1000; max_gap = 0;
        kick(21'h100);
        wait_done(5000, c, ok);
        n_vec++; if (!ok || c + 1 != 2 + 3 * SW) begin n_err++; $display("FAIL full_cycles got %0d (done seen %b) want %0d", c + 1, ok, 2 + 3 * SW); end
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL full_idle busy=%b done=%b want 0 0", busy, done); end
        n_vec++; if (wr_count - w0 != SW) begin n_err++; $display("FAIL full_writes got %0d want %0d", wr_count - w0, SW); end
        n_vec++; if (done_count - d0 != 1) begin n_err++; $display("FAIL full_done_pulses got %0d want 1", done_count - d0); end
        n_vec++; if (min_gap != 3 || max_gap != 3) begin n_err++; $display("FAIL full_spacing got %0d..%0d want 3..3", min_gap, max_gap); end
        n_vec++; if (acks_given - addr_start_ack != SW) begin n_err++; $display("FAIL full_fetches got %0d want %0d", acks_given - addr_start_ack, SW); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL full_leftover got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_ready_wait;
        int c, w0; bit ok, bad;
        fifo_ready = 0; w0 = wr_count; bad = 0;
        kick(21'h200);
        repeat (49) begin
            @(negedge clk);
            if (mem_rd !== 1'b0 || fifo_wr !== 1'b0) bad = 1;
        end
        n_vec++; if (bad) begin n_err++; $display("FAIL ready_gate activity seen=1 want 0"); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL ready_busy got %b want 1", busy); end
        fifo_ready = 1;
        @(negedge clk);
        n_vec++; if (mem_rd !== 1'b1) begin n_err++; $display("FAIL ready_first_rd got %b want 1", mem_rd); end
        fifo_ready = 0;
        wait_done(5000, c, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL ready_done timeout got 0 want 1"); end
        @(negedge clk);
        n_vec++; if (wr_count - w0 != SW) begin n_err++; $display("FAIL ready_writes got %0d want %0d", wr_count - w0, SW); end
        fifo_ready = 1;
    endtask

    task automatic test_abort(input int nwords);
        int w0, d0, pad; bit ok;
        fifo_ready = 1; delay_max = 0;
        w0 = wr_count; d0 = done_count;
        ack_limit = acks_given + nwords;
        kick(21'h300);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (mem_rd === 1'b1 && acks_given == ack_limit && wr_count - w0 == nwords) ok = 1;
        end
        n_vec++; if (!ok) begin n_err++; $display("FAIL abort%0d_setup reached=0 want 1", nwords); end
        pad = nwords % 2;
        if (pad != 0) exp_q.push_back(16'h0000);
        abort = 1;
        @(negedge clk);
        abort = 0;
        n_vec++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL abort%0d_rd_drop got %b want 0", nwords, mem_rd); end
        n_vec++; if (busy !== (pad != 0)) begin n_err++; $display("FAIL abort%0d_busy got %b want %0d", nwords, busy, pad); end
        repeat (8) @(negedge clk);
        n_vec++; if (wr_count - w0 != nwords + pad) begin n_err++; $display("FAIL abort%0d_writes got %0d want %0d", nwords, wr_count - w0, nwords + pad); end
        n_vec++; if (done_count != d0) begin n_err++; $display("FAIL abort%0d_done got %0d want 0", nwords, done_count - d0); end
        n_vec++; if (busy !== 1'b0 || exp_q.size() != 0) begin n_err++; $display("FAIL abort%0d_end busy=%b left=%0d want 0 0", nwords, busy, exp_q.size()); end
        ack_limit = 1 << 30;
    endtask

    task automatic test_mute_wrap;
        int c, w0, z0; bit ok;
        mute = 1; fixed_en = 1; fixed_val = 16'hABCD;
        w0 = wr_count; z0 = zero_addr_cnt;
        kick({AW{1'b1}});
        wait_done(5000, c, ok);
        @(negedge clk);
        n_vec++; if (!ok || wr_count - w0 != SW) begin n_err++; $display("FAIL mute_writes got %0d want %0d", wr_count - w0, SW); end
        n_vec++; if (zero_addr_cnt - z0 != 1) begin n_err++; $display("FAIL wrap_zero_addr got %0d want 1", zero_addr_cnt - z0); end
        mute = 0; fixed_en = 0;
    endtask

    task automatic test_ack_delay;
        int c, w0, d0, r0; bit ok;
        delay_max = 5; w0 = wr_count; d0 = done_count; r0 = rd_rises;
        kick(21'h2345);
        wait_done(SW * 10, c, ok);
        @(negedge clk);
        n_vec++; if (!ok || wr_count - w0 != SW) begin n_err++; $display("FAIL delay_writes got %0d want %0d", wr_count - w0, SW); end
        n_vec++; if (rd_rises - r0 != SW) begin n_err++; $display("FAIL delay_rd_held got %0d requests want %0d", rd_rises - r0, SW); end
        n_vec++; if (done_count - d0 != 1) begin n_err++; $display("FAIL delay_done got %0d want 1", done_count - d0); end
        delay_max = 0;
    endtask

    task automatic test_start_busy_reset;
        int c, w0, d0; bit ok;
        w0 = wr_count;
        @(negedge clk);
        base = 21'h80; start = 1; abort = 1;
        addr_base = 21'h80; addr_start_ack = acks_given;
        @(negedge clk);
        start = 0; abort = 0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL start_beats_abort busy=%b want 1", busy); end
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (wr_count - w0 >= 10) ok = 1;
        end
        base = 21'h7000; start = 1;
        @(negedge clk);
        start = 0;
        ack_limit = acks_given;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (mem_rd === 1'b1) ok = 1;
        end
        n_vec++; if (!ok) begin n_err++; $display("FAIL busy_fetch reached=0 want 1"); end
        nrst = 0;
        @(negedge clk);
        n_vec++; if ({mem_rd, fifo_wr, busy, done} !== 4'b0 || mem_addr !== '0 || fifo_dout !== '0) begin
            n_err++; $display("FAIL midreset_outputs rd=%b wr=%b busy=%b done=%b addr=%h dout=%h want all 0", mem_rd, fifo_wr, busy, done, mem_addr, fifo_dout);
        end
        nrst = 1;
        exp_q.delete();
        ack_limit = 1 << 30;
        w0 = wr_count; d0 = done_count;
        kick(21'h40);
        wait_done(5000, c, ok);
        @(negedge clk);
        n_vec++; if (!ok || wr_count - w0 != SW) begin n_err++; $display("FAIL restart_writes got %0d want %0d", wr_count - w0, SW); end
        n_vec++; if (done_count - d0 != 1) begin n_err++; $display("FAIL restart_done got %0d want 1", done_count - d0); end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        acks_given = 0; ack_limit = 1 << 30; wait_left = 0; delay_max = 0;
        wr_count = 0; done_count = 0; rd_rises = 0; zero_addr_cnt = 0;
        cyc = 0; last_wr_cyc = 0; min_gap = 1000; max_gap = 0; addr_start_ack = 0;
        first_wr = 1; fixed_en = 0; prev_wr = 0; prev_rd = 0;
        prev_dout = '0; fixed_val = '0; addr_base = '0; exp_addr = '0;
        nrst = 0; start = 0; abort = 0; mute = 0; base = '0; fifo_ready = 0;
        mem_ack = 0; mem_data = '0;

        // Memory responder and FIFO-side scoreboard, sampled on the falling edge.
        fork
            forever begin
                @(negedge clk);
                cyc++;
                mem_ack = 1'b0;
                if (mem_rd === 1'b1 && acks_given < ack_limit) begin
                    if (wait_left > 0) begin
                        wait_left--;
                    end else begin
                        mem_ack  = 1'b1;
                        mem_data = fixed_en ? fixed_val : mem_addr[15:0];
                        exp_addr = addr_base + AW'(acks_given - addr_start_ack);
                        n_vec++;
                        if (mem_addr !== exp_addr) begin n_err++; $display("FAIL mem_addr got %h want %h", mem_addr, exp_addr); end
                        if (mem_addr == '0) zero_addr_cnt++;
                        exp_q.push_back(mute ? 16'h0000 : mem_data);
                        acks_given++;
                        wait_left = $urandom_range(0, delay_max);
                    end
                end
                if (mem_rd === 1'b1 && !prev_rd) rd_rises++;
                if (fifo_wr === 1'b1 && prev_wr) begin
                    n_vec++; n_err++; $display("FAIL wr_back_to_back got 2 consecutive strobes want 1");
                end
                if (fifo_wr === 1'b1 && !prev_wr) begin
                    wr_count++;
                    if (!first_wr) begin
                        if (cyc - last_wr_cyc < min_gap) min_gap = cyc - last_wr_cyc;
                        if (cyc - last_wr_cyc > max_gap) max_gap = cyc - last_wr_cyc;
                    end
                    first_wr = 0; last_wr_cyc = cyc;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++; $display("FAIL fifo_word unexpected write data %h want none", fifo_dout);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (fifo_dout !== exp_w) begin n_err++; $display("FAIL fifo_word got %h want %h", fifo_dout, exp_w); end
                    end
                end
                if (fifo_wr === 1'b0 && prev_wr) begin
                    n_vec++;
                    if (fifo_dout !== prev_dout) begin n_err++; $display("FAIL dout_hold got %h want %h", fifo_dout, prev_dout); end
                end
                if (done === 1'b1) done_count++;
                prev_wr = (fifo_wr === 1'b1); prev_rd = (mem_rd === 1'b1); prev_dout = fifo_dout;
            end
        join_none

        test_reset;
        test_full_sector;
        test_ready_wait;
        test_abort(7);
        test_abort(8);
        test_mute_wrap;
        test_ack_delay;
        test_start_busy_reset;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
